phase_select_ctrl: RTL and testbench

PHASE_SELECT_CTRL -- requirements
Module: phase_select_ctrl

---
 rtl/phase_select_ctrl.sv | 167 ++++++++++++++++
 tb/tb_phase_select_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/phase_select_ctrl.sv
// phase_select_ctrl: early/late vote tracker that steps a 5-phase clock select.
// Rev 1.0
`default_nettype none

module phase_select_ctrl #(
   parameter int WIN_LEN  = 16,
   parameter int VOTE_TH  = 8,
   parameter int LOCK_CNT = 4,
   parameter int HOLDOFF  = 20
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       enable,
   input  logic       sample_valid,
   input  logic       early,
   input  logic       late,
   input  logic       force_valid,
   input  logic [2:0] force_phase,
   output logic [2:0] phase_sel,
   output logic [4:0] phase_onehot,
   output logic       shift_pulse,
   output logic       locked
);

   localparam int VW = $clog2(WIN_LEN) + 1;
   localparam int CW = $clog2(WIN_LEN);
   localparam int NW = VW + 1;
   localparam logic signed [NW-1:0] ONE   = NW'(1);
   localparam logic signed [NW-1:0] TH_P  = NW'(VOTE_TH);
   localparam logic signed [NW-1:0] TH_N  = NW'(-VOTE_TH);
   localparam logic [7:0]           HOLD8 = 8'(HOLDOFF);
   localparam logic [3:0]           LOCK4 = 4'(LOCK_CNT);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACQ   = 2'd1,
      ST_TRACK = 2'd2
   } state_t;

   state_t               state_q;
   logic signed [VW-1:0] vote_q;
   logic [CW-1:0]        win_q;
   logic [7:0]           hold_q;
   logic [3:0]           nostep_q;
   logic                 stepped_q;
   logic [2:0]           phase_q;
   logic [4:0]           onehot_q;
   logic                 pulse_q;
   logic                 locked_q;

   logic signed [NW-1:0] net_d;
   logic                 accept;
   logic                 win_end;
   logic                 step_up;
   logic                 step_dn;
   logic                 force_ok;
   logic [2:0]           phase_up;
   logic [2:0]           phase_dn;

   function automatic logic [4:0] dec5(input logic [2:0] p);
      dec5 = 5'd1 << p;
   endfunction

   // The stored accumulator only ever holds WIN_LEN-1 votes; the final vote is
   // folded in one bit wider so the decision itself cannot overflow.
   always_comb begin
      accept   = sample_valid && (state_q != ST_IDLE) && (hold_q == 8'd0);
      net_d    = {vote_q[VW-1], vote_q};
      if (early && !late) begin
         net_d = net_d + ONE;
      end else if (late && !early) begin
         net_d = net_d - ONE;
      end
      win_end  = accept && (win_q == CW'(WIN_LEN - 1));
      step_up  = win_end && (net_d >= TH_P);
      step_dn  = win_end && (net_d <= TH_N);
      force_ok = force_valid && (force_phase <= 3'd4);
      phase_up = (phase_q == 3'd4) ? 3'd0 : phase_q + 3'd1;
      phase_dn = (phase_q == 3'd0) ? 3'd4 : phase_q - 3'd1;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         vote_q    <= '0;
         win_q     <= '0;
         hold_q    <= '0;
         nostep_q  <= '0;
         stepped_q <= 1'b0;
         phase_q   <= 3'd0;
         onehot_q  <= 5'b00001;
         pulse_q   <= 1'b0;
         locked_q  <= 1'b0;
      end else begin
         pulse_q <= 1'b0;
         if (!enable) begin
            state_q   <= ST_IDLE;
            vote_q    <= '0;
            win_q     <= '0;
            hold_q    <= '0;
            nostep_q  <= '0;
            stepped_q <= 1'b0;
            locked_q  <= 1'b0;
         end else if (state_q == ST_IDLE) begin
            state_q <= ST_ACQ;
         end else if (force_ok) begin
            phase_q   <= force_phase;
            onehot_q  <= dec5(force_phase);
            pulse_q   <= (force_phase != phase_q);
            hold_q    <= HOLD8;
            vote_q    <= '0;
            win_q     <= '0;
            nostep_q  <= '0;
            stepped_q <= 1'b0;
            state_q   <= ST_ACQ;
            locked_q  <= 1'b0;
         end else begin
            if (hold_q != 8'd0) begin
               hold_q <= hold_q - 8'd1;
            end
            if (win_end) begin
               vote_q <= '0;
               win_q  <= '0;
               if (step_up || step_dn) begin
                  phase_q  <= step_up ? phase_up : phase_dn;
                  onehot_q <= dec5(step_up ? phase_up : phase_dn);
                  pulse_q  <= 1'b1;
                  hold_q   <= HOLD8;
                  nostep_q <= '0;
                  // In TRACK, a step right after a stepping window means lock was lost.
                  if (state_q == ST_TRACK) begin
                     if (stepped_q) begin
                        state_q   <= ST_ACQ;
                        locked_q  <= 1'b0;
                        stepped_q <= 1'b0;
                     end else begin
                        stepped_q <= 1'b1;
                     end
                  end
               end else begin
                  stepped_q <= 1'b0;
                  if (state_q == ST_ACQ) begin
                     if (nostep_q == LOCK4 - 4'd1) begin
                        state_q  <= ST_TRACK;
                        locked_q <= 1'b1;
                        nostep_q <= '0;
                     end else begin
                        nostep_q <= nostep_q + 4'd1;
                     end
                  end
               end
            end else if (accept) begin
               vote_q <= net_d[VW-1:0];
               win_q  <= win_q + CW'(1);
            end
         end
      end
   end

   assign phase_sel    = phase_q;
   assign phase_onehot = onehot_q;
   assign shift_pulse  = pulse_q;
   assign locked       = locked_q;

endmodule

`default_nettype wire

// File: tb/tb_phase_select_ctrl.sv
// tb_phase_select_ctrl: window table, hand sequences and random run against a vote-list model.
// Rev 1.0
`default_nettype none

module tb_phase_select_ctrl;

   localparam int WIN_LEN  = 16;
   localparam int VOTE_TH  = 8;
   localparam int LOCK_CNT = 4;
   localparam int HOLDOFF  = 20;

   logic       clock = 1'b0;
   logic       reset_n;
   logic       enable;
   logic       sample_valid;
   logic       early;
   logic       late;
   logic       force_valid;
   logic [2:0] force_phase;
   logic [2:0] phase_sel;
   logic [4:0] phase_onehot;
   logic       shift_pulse;
   logic       locked;

   phase_select_ctrl #(
      .WIN_LEN (WIN_LEN),
      .VOTE_TH (VOTE_TH),
      .LOCK_CNT(LOCK_CNT),
      .HOLDOFF (HOLDOFF)
   ) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .enable      (enable),
      .sample_valid(sample_valid),
      .early       (early),
      .late        (late),
      .force_valid (force_valid),
      .force_phase (force_phase),
      .phase_sel   (phase_sel),
      .phase_onehot(phase_onehot),
      .shift_pulse (shift_pulse),
      .locked      (locked)
   );

   always #5 clock = ~clock;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int pulse_cnt = 0;

   // Reference model: mode 0 idle / 1 acquiring / 2 tracking, window kept as a vote list.
   int m_phase, m_mode, m_hold, m_clean;
   bit m_last_step, m_pulse;
   int m_votes[$];

   task automatic model_reset();
      m_phase = 0; m_mode = 0; m_hold = 0; m_clean = 0;
      m_last_step = 1'b0; m_pulse = 1'b0;
      m_votes.delete();
   endtask

   task automatic model_step();
      int sum, dir;
      bit take;
      m_pulse = 1'b0;
      if (!reset_n) begin
         model_reset();
      end else if (!enable) begin
         m_mode = 0; m_hold = 0; m_clean = 0; m_last_step = 1'b0;
         m_votes.delete();
      end else if (m_mode == 0) begin
         m_mode = 1;
      end else if (force_valid && force_phase < 3'd5) begin
         m_pulse = (int'(force_phase) != m_phase);
         m_phase = int'(force_phase);
         m_hold = HOLDOFF; m_clean = 0; m_last_step = 1'b0; m_mode = 1;
         m_votes.delete();
      end else begin
         take = sample_valid && (m_hold == 0);
         if (m_hold > 0) m_hold--;
         if (take) begin
            m_votes.push_back((early && !late) ? 1 : (late && !early) ? -1 : 0);
            if (m_votes.size() == WIN_LEN) begin
               sum = 0;
               foreach (m_votes[k]) sum += m_votes[k];
               m_votes.delete();
               dir = (sum >= VOTE_TH) ? 1 : (sum <= -VOTE_TH) ? -1 : 0;
               if (dir != 0) begin
                  m_phase = (m_phase + dir + 5) % 5;
                  m_pulse = 1'b1; m_hold = HOLDOFF; m_clean = 0;
                  if (m_mode == 2) begin
                     if (m_last_step) begin
                        m_mode = 1; m_last_step = 1'b0;
                     end else begin
                        m_last_step = 1'b1;
                     end
                  end
               end else begin
                  m_last_step = 1'b0;
                  if (m_mode == 1) begin
                     m_clean++;
                     if (m_clean == LOCK_CNT) begin
                        m_mode = 2; m_clean = 0;
                     end
                  end
               end
            end
         end
      end
   endtask

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, exp);
      end
   endtask

   task automatic tick();
      logic [9:0] exp_v, act_v;
      @(posedge clock);
      model_step();
      #1;
      cyc++;
      exp_v = {3'(m_phase), 5'(1 << m_phase), m_pulse, (m_mode == 2)};
      act_v = {phase_sel, phase_onehot, shift_pulse, locked};
      n_cmp++;
      if (act_v !== exp_v) begin
         n_err++;
         $display("FAIL model cyc=%0d actual=%b required=%b (phase,onehot,pulse,locked)",
                  cyc, act_v, exp_v);
      end
      if (shift_pulse === 1'b1) pulse_cnt++;
   endtask

   task automatic idle(input int n);
      sample_valid = 1'b0; early = 1'b0; late = 1'b0; force_valid = 1'b0;
      repeat (n) tick();
   endtask

   // One valid sample per cycle, categories interleaved round-robin: early, late, both, neither.
   task automatic send_window(input int ne, input int nl, input int nb, input int nn);
      int c[4];
      int p, total;
      c[0] = ne; c[1] = nl; c[2] = nb; c[3] = nn;
      total = ne + nl + nb + nn;
      p = 0;
      for (int k = 0; k < total; k++) begin
         while (c[p] == 0) p = (p + 1) % 4;
         sample_valid = 1'b1;
         early = (p == 0) || (p == 2);
         late  = (p == 1) || (p == 2);
         c[p]--;
         p = (p + 1) % 4;
         tick();
      end
      sample_valid = 1'b0; early = 1'b0; late = 1'b0;
   endtask

   typedef struct {
      int ne, nl, nb, nn;
      int ph;
      int pulses;
      int lk;
   } win_t;

   win_t tbl[14];

   initial begin
      int pe, pl;
      tbl[0]  = '{16, 0, 0, 0, 1, 1, 0};
      tbl[1]  = '{16, 0, 0, 0, 2, 1, 0};
      tbl[2]  = '{16, 0, 0, 0, 3, 1, 0};
      tbl[3]  = '{16, 0, 0, 0, 4, 1, 0};
      tbl[4]  = '{16, 0, 0, 0, 0, 1, 0};
      tbl[5]  = '{0, 16, 0, 0, 4, 1, 0};
      tbl[6]  = '{8, 0, 8, 0, 0, 1, 0};
      tbl[7]  = '{8, 8, 0, 0, 0, 0, 0};
      tbl[8]  = '{8, 8, 0, 0, 0, 0, 0};
      tbl[9]  = '{8, 8, 0, 0, 0, 0, 0};
      tbl[10] = '{8, 8, 0, 0, 0, 0, 1};
      tbl[11] = '{7, 0, 0, 9, 0, 0, 1};
      tbl[12] = '{0, 16, 0, 0, 4, 1, 1};
      tbl[13] = '{0, 16, 0, 0, 3, 1, 0};

      reset_n = 1'b0; enable = 1'b0; sample_valid = 1'b0; early = 1'b0; late = 1'b0;
      force_valid = 1'b0; force_phase = 3'd0;
      model_reset();
      tick(); tick();
      check("reset_phase", int'(phase_sel), 0);
      check("reset_onehot", int'(phase_onehot), 1);
      check("reset_locked", int'(locked), 0);
      reset_n = 1'b1;
      enable  = 1'b1;
      tick();

      for (int i = 0; i < 14; i++) begin
         pulse_cnt = 0;
         send_window(tbl[i].ne, tbl[i].nl, tbl[i].nb, tbl[i].nn);
         idle(22);
         check($sformatf("win%0d_phase", i), int'(phase_sel), tbl[i].ph);
         check($sformatf("win%0d_pulses", i), pulse_cnt, tbl[i].pulses);
         check($sformatf("win%0d_locked", i), int'(locked), tbl[i].lk);
      end

      // Holdoff: the 20 samples right after a step must not count.
      send_window(16, 0, 0, 0);
      check("hold_step_phase", int'(phase_sel), 4);
      pulse_cnt = 0;
      send_window(35, 0, 0, 0);
      check("hold_ignored_phase", int'(phase_sel), 4);
      check("hold_ignored_pulses", pulse_cnt, 0);
      send_window(1, 0, 0, 0);
      check("hold_resume_phase", int'(phase_sel), 0);
      check("hold_resume_pulse", int'(shift_pulse), 1);

      // Force on the window-end cycle beats the window decision.
      idle(22);
      send_window(15, 0, 0, 0);
      sample_valid = 1'b1; early = 1'b1; force_valid = 1'b1; force_phase = 3'd3;
      tick();
      check("force_end_phase", int'(phase_sel), 3);
      check("force_end_pulse", int'(shift_pulse), 1);
      idle(1);
      check("force_pulse_single", int'(shift_pulse), 0);
      force_valid = 1'b1; force_phase = 3'd6;
      tick();
      check("force_illegal_phase", int'(phase_sel), 3);
      check("force_illegal_pulse", int'(shift_pulse), 0);
      enable = 1'b0; force_phase = 3'd1;
      tick();
      check("force_vs_disable", int'(phase_sel), 3);
      force_valid = 1'b0; enable = 1'b1;
      idle(22);

      // Lock, then async reset mid-window; lock must need four fresh windows.
      for (int w = 0; w < 4; w++) send_window(8, 8, 0, 0);
      check("relock_locked", int'(locked), 1);
      send_window(5, 0, 0, 0);
      #2 reset_n = 1'b0;
      #1;
      check("arst_phase", int'(phase_sel), 0);
      check("arst_onehot", int'(phase_onehot), 1);
      check("arst_pulse", int'(shift_pulse), 0);
      check("arst_locked", int'(locked), 0);
      model_reset();
      tick();
      reset_n = 1'b1;
      tick();
      for (int w = 0; w < 3; w++) send_window(8, 8, 0, 0);
      send_window(6, 5, 0, 0);
      check("arst_no_early_lock", int'(locked), 0);
      send_window(2, 3, 0, 0);
      check("arst_fresh_lock", int'(locked), 1);

      pe = 5; pl = 5;
      for (int i = 0; i < 3000; i++) begin
         if (i % 32 == 0) begin
            case ($urandom_range(0, 2))
               0:       begin pe = 9; pl = 1; end
               1:       begin pe = 1; pl = 9; end
               default: begin pe = 5; pl = 5; end
            endcase
         end
         enable       = ($urandom_range(0, 199) != 0);
         sample_valid = ($urandom_range(0, 9) < 7);
         early        = ($urandom_range(0, 9) < pe);
         late         = ($urandom_range(0, 9) < pl);
         force_valid  = ($urandom_range(0, 99) == 0);
         force_phase  = 3'($urandom_range(0, 7));
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
